// File: rtl/cam_pkg.sv
// Shared encodings for the OV7670 capture path and the VGA colour constants.
package cam_pkg;

    // Pixel format selected by MODE
    localparam logic [1:0] ModeRgb332    = 2'd0;
    localparam logic [1:0] ModeGray      = 2'd1;
    localparam logic [1:0] ModeSwap      = 2'd2;
    localparam logic [1:0] ModeRgb332Alt = 2'd3;

    // Decimation selected by DECIM (2 and 3 both mean 1:4)
    localparam logic [1:0] Decim1 = 2'd0;
    localparam logic [1:0] Decim2 = 2'd1;
    localparam logic [1:0] Decim4 = 2'd2;

    // RGB332 colours shared with the VGA path
    localparam logic [7:0] Rgb332Black = 8'h00;
    localparam logic [7:0] Rgb332Red   = 8'hE0;
    localparam logic [7:0] Rgb332Green = 8'h1C;
    localparam logic [7:0] Rgb332Blue  = 8'h03;
    localparam logic [7:0] Rgb332White = 8'hFF;

    typedef enum logic {StIdle, StFrame} cap_state_e;

    // k-1 for the decimation factor k; a counter is kept when (cnt & mask) == 0
    function automatic logic [1:0] decim_mask(input logic [1:0] decim);
        case (decim)
            Decim1:  return 2'b00;
            Decim2:  return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// Camera pins plus frame-buffer write port and status of the capture block.
interface ov7670_capture_if #(
    parameter int unsigned ADDR_W = 15
) ();
    logic              VSYNC;
    logic              HREF;
    logic [7:0]        CAM_DATA;
    logic [1:0]        MODE;
    logic [1:0]        DECIM;
    logic [7:0]        WR_DATA;
    logic [ADDR_W-1:0] WR_ADDR;
    logic              W_EN;
    logic              FRAME_DONE;
    logic [7:0]        FRAME_CNT;
    logic              OVERFLOW;
    logic              BUSY;

    // Capture block: consumes camera pins, drives frame-buffer writes
    modport master (
        input  VSYNC, HREF, CAM_DATA, MODE, DECIM,
        output WR_DATA, WR_ADDR, W_EN, FRAME_DONE, FRAME_CNT, OVERFLOW, BUSY
    );

    // Camera / frame-buffer side
    modport slave (
        output VSYNC, HREF, CAM_DATA, MODE, DECIM,
        input  WR_DATA, WR_ADDR, W_EN, FRAME_DONE, FRAME_CNT, OVERFLOW, BUSY
    );
endinterface

// File: rtl/pixel_convert.sv
// Combinational RGB565 word to 8-bit pixel (RGB332 or grayscale).
module pixel_convert
    import cam_pkg::*;
(
    input  logic [15:0] pix_i,
    input  logic [1:0]  mode_i,
    output logic [7:0]  pix_o
);
    logic [7:0] r8, g8, b8;
    logic [9:0] sum;

    // Expand channels by MSB replication and form Y = (R + 2G + B) / 4
    always_comb begin
        r8    = {pix_i[15:11], pix_i[15:13]};
        g8    = {pix_i[10:5], pix_i[10:9]};
        b8    = {pix_i[4:0], pix_i[4:2]};
        sum   = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};
        pix_o = {pix_i[15:13], pix_i[10:8], pix_i[4:3]};
        if (mode_i == ModeGray) begin
            pix_o = 8'(sum >> 2);
        end
    end
endmodule

// File: rtl/ov7670_capture.sv
// OV7670 byte stream to decimated, clipped 8-bit frame-buffer writes.
module ov7670_capture
    import cam_pkg::*;
#(
    parameter int unsigned IMG_W  = 176,
    parameter int unsigned IMG_H  = 144,
    parameter int unsigned ADDR_W = 15
) (
    input logic CLK,
    input logic RESET_N,
    ov7670_capture_if.master cam
);
    // One spare bit so row_base can hold IMG_W*IMG_H and x_out can run past IMG_W
    localparam int unsigned CW = ADDR_W + 1;
    localparam logic [CW-1:0] ImgW   = CW'(IMG_W);
    localparam logic [CW-1:0] ImgH   = CW'(IMG_H);
    localparam logic [CW-1:0] CntMax = '1;

    cap_state_e        state_q, state_d;
    logic              vs_prev_q, href_prev_q;
    logic [1:0]        mode_q, mode_d, decim_q, decim_d;
    logic              phase_q, phase_d;
    logic [7:0]        byte0_q, byte0_d;
    logic [1:0]        src_x_q, src_x_d, line_q, line_d;
    logic [CW-1:0]     x_q, x_d, y_q, y_d, row_q, row_d;
    logic              ovf_q, ovf_d;
    logic              wen_q, wen_d, done_q, done_d, overflow_q, overflow_d;
    logic [7:0]        wdata_q, wdata_d, cnt_q, cnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;

    logic        vs_rise, href_rise, href_fall, keep_pix, keep_line;
    logic [1:0]  mask;
    logic [15:0] pix_word;
    logic [7:0]  pix_conv;

    assign vs_rise   = cam.VSYNC & ~vs_prev_q;
    assign href_rise = cam.HREF & ~href_prev_q;
    assign href_fall = ~cam.HREF & href_prev_q;
    assign mask      = decim_mask(decim_q);
    assign keep_pix  = ((src_x_q & mask) == 2'b00) && ((line_q & mask) == 2'b00);
    assign keep_line = (line_q & mask) == 2'b00;
    assign pix_word  = (mode_q == ModeSwap) ? {cam.CAM_DATA, byte0_q} : {byte0_q, cam.CAM_DATA};

    pixel_convert u_convert (
        .pix_i  (pix_word),
        .mode_i (mode_q),
        .pix_o  (pix_conv)
    );

    // Next state: frame sync first, then byte assembly and line bookkeeping
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        decim_d    = decim_q;
        phase_d    = phase_q;
        byte0_d    = byte0_q;
        src_x_d    = src_x_q;
        line_d     = line_q;
        x_d        = x_q;
        y_d        = y_q;
        row_d      = row_q;
        ovf_d      = ovf_q;
        wen_d      = 1'b0;
        wdata_d    = wdata_q;
        waddr_d    = waddr_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;

        if (vs_rise) begin
            if (state_q == StFrame) begin
                done_d     = 1'b1;
                cnt_d      = cnt_q + 8'd1;
                overflow_d = ovf_q;
            end
            state_d = StFrame;
            mode_d  = cam.MODE;
            decim_d = cam.DECIM;
            src_x_d = '0;
            line_d  = '0;
            x_d     = '0;
            y_d     = '0;
            row_d   = '0;
            ovf_d   = 1'b0;
            // A line starting on the same edge contributes its byte 0 to line 0
            phase_d = href_rise;
            byte0_d = cam.CAM_DATA;
        end else if (state_q == StFrame) begin
            if (href_rise) begin
                phase_d = 1'b1;
                byte0_d = cam.CAM_DATA;
                src_x_d = '0;
                x_d     = '0;
            end else if (cam.HREF) begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    byte0_d = cam.CAM_DATA;
                end else begin
                    phase_d = 1'b0;
                    src_x_d = src_x_q + 2'd1;
                    if (keep_pix) begin
                        x_d = (x_q == CntMax) ? x_q : x_q + 1'b1;
                        if (x_q < ImgW && y_q < ImgH) begin
                            wen_d   = 1'b1;
                            wdata_d = pix_conv;
                            waddr_d = ADDR_W'(row_q + x_q);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end else if (href_fall) begin
                phase_d = 1'b0;
                line_d  = line_q + 2'd1;
                if (keep_line && y_q < ImgH) begin
                    y_d   = y_q + 1'b1;
                    row_d = row_q + ImgW;
                end
            end
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StIdle;
            vs_prev_q   <= 1'b0;
            href_prev_q <= 1'b0;
            mode_q      <= '0;
            decim_q     <= '0;
            phase_q     <= 1'b0;
            byte0_q     <= '0;
            src_x_q     <= '0;
            line_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            row_q       <= '0;
            ovf_q       <= 1'b0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            waddr_q     <= '0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_prev_q   <= cam.VSYNC;
            href_prev_q <= cam.HREF;
            mode_q      <= mode_d;
            decim_q     <= decim_d;
            phase_q     <= phase_d;
            byte0_q     <= byte0_d;
            src_x_q     <= src_x_d;
            line_q      <= line_d;
            x_q         <= x_d;
            y_q         <= y_d;
            row_q       <= row_d;
            ovf_q       <= ovf_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign cam.W_EN       = wen_q;
    assign cam.WR_DATA    = wdata_q;
    assign cam.WR_ADDR    = waddr_q;
    assign cam.FRAME_DONE = done_q;
    assign cam.FRAME_CNT  = cnt_q;
    assign cam.OVERFLOW   = overflow_q;
    assign cam.BUSY       = (state_q == StFrame);
endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture with a small frame buffer and random pixels.
module tb_ov7670_capture;
    import cam_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned H  = 12;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ov7670_capture_if #(.ADDR_W(AW)) bus ();

    ov7670_capture #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .cam     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    int   done_exp = 0;
    int   cnt_exp = 0;
    bit   ovf_exp = 0;
    bit   ovf_frame = 0;
    bit   busy_exp = 0;
    logic [1:0] frame_mode = 2'd0;
    logic [1:0] frame_decim = 2'd0;
    int   line_idx = 0;
    logic wen_prev = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference pixel straight from the format rules
    function automatic int ref_pixel(input logic [15:0] p, input logic [1:0] mode);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(p[15:11]);
        g6 = int'(p[10:5]);
        b5 = int'(p[4:0]);
        if (mode == 2'd1) begin
            r8 = r5 * 8 + r5 / 4;
            g8 = g6 * 4 + g6 / 16;
            b8 = b5 * 8 + b5 / 4;
            return (r8 + 2 * g8 + b8) / 4;
        end
        return (r5 / 4) * 32 + (g6 / 8) * 4 + (b5 / 8);
    endfunction

    // Frame boundary in the model: close the running frame, open a new one
    task automatic model_vsync();
        if (busy_exp) begin
            done_exp++;
            cnt_exp = (cnt_exp + 1) % 256;
            ovf_exp = ovf_frame;
        end
        busy_exp    = 1;
        ovf_frame   = 0;
        frame_mode  = bus.MODE;
        frame_decim = bus.DECIM;
        line_idx    = 0;
    endtask

    task automatic model_pixel(input int px, input logic [7:0] b0, input logic [7:0] b1);
        int k, x, y;
        logic [15:0] p;
        wr_t e;
        if (!busy_exp) return;
        k = (frame_decim == 2'd0) ? 1 : (frame_decim == 2'd1) ? 2 : 4;
        if (px % k != 0 || line_idx % k != 0) return;
        x = px / k;
        y = line_idx / k;
        p = (frame_mode == 2'd2) ? {b1, b0} : {b0, b1};
        if (x < int'(W) && y < int'(H)) begin
            e.addr = AW'(y * int'(W) + x);
            e.data = 8'(ref_pixel(p, frame_mode));
            exp_q.push_back(e);
        end else begin
            ovf_frame = 1;
        end
    endtask

    // Monitor: pops the scoreboard on every write strobe
    always @(negedge clk) begin
        wr_t e;
        if (bus.FRAME_DONE) done_seen++;
        if (bus.W_EN) begin
            if (wen_prev) check("wen_consecutive", 1, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", bus.WR_ADDR, 'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", bus.WR_ADDR, e.addr);
                check("wr_data", bus.WR_DATA, e.data);
            end
        end
        wen_prev = bus.W_EN;
    end

    task automatic vsync_edge();
        @(negedge clk);
        bus.HREF  = 1'b0;
        bus.VSYNC = 1'b1;
        model_vsync();
        @(negedge clk);
        @(negedge clk);
        bus.VSYNC = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // One HREF burst; pairs of bytes are either random or the fixed word {first, second}
    task automatic send_line(input int nbytes, input bit rnd, input logic [15:0] fixed,
                             input bit with_vs);
        logic [15:0] w;
        logic [7:0]  b0;
        w = fixed;
        b0 = 8'h00;
        for (int j = 0; j < nbytes; j++) begin
            @(negedge clk);
            if (j % 2 == 0) w = rnd ? 16'($urandom) : fixed;
            bus.HREF     = 1'b1;
            bus.CAM_DATA = (j % 2 == 0) ? w[15:8] : w[7:0];
            if (j == 0 && with_vs) begin
                bus.VSYNC = 1'b1;
                model_vsync();
            end
            if (j % 2 == 0) b0 = w[15:8];
            else model_pixel(j / 2, b0, w[7:0]);
        end
        @(negedge clk);
        bus.HREF     = 1'b0;
        bus.VSYNC    = 1'b0;
        bus.CAM_DATA = 8'($urandom);
        if (busy_exp) line_idx++;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_done_count"}, done_seen, done_exp);
        check({tag, "_frame_cnt"}, bus.FRAME_CNT, cnt_exp);
        check({tag, "_overflow"}, bus.OVERFLOW, ovf_exp);
        check({tag, "_busy"}, bus.BUSY, busy_exp);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    // Set config, sync, and stream a frame; status of the previous frame is checked at the sync
    task automatic frame(input string tag, input logic [1:0] mode, input logic [1:0] decim,
                         input int lines, input int nbytes, input bit rnd,
                         input logic [15:0] fixed, input bit mid_change);
        bus.MODE  = mode;
        bus.DECIM = decim;
        vsync_edge();
        check_status(tag);
        for (int l = 0; l < lines; l++) begin
            send_line(nbytes, rnd, fixed, 1'b0);
            if (mid_change && l == 0) begin
                bus.MODE  = ~mode;
                bus.DECIM = ~decim;
            end
        end
    endtask

    initial begin
        bus.VSYNC = 0; bus.HREF = 0; bus.CAM_DATA = 0; bus.MODE = 0; bus.DECIM = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.W_EN, bus.WR_DATA, bus.WR_ADDR, bus.FRAME_DONE,
                                bus.FRAME_CNT, bus.OVERFLOW, bus.BUSY}, 0);
        rst_n = 1'b1;
        // Unarmed: data before the first VSYNC must be ignored
        send_line(2 * W, 1'b1, 16'h0, 1'b0);
        check("unarmed_busy", bus.BUSY, 0);

        frame("red",     2'd0, 2'd0, H,     2 * W,     1'b0, 16'hF800, 1'b0);
        frame("white",   2'd1, 2'd0, 2,     2 * W,     1'b0, 16'hFFFF, 1'b0);
        frame("green",   2'd1, 2'd0, 2,     2 * W,     1'b0, 16'h07E0, 1'b0);
        frame("swap",    2'd2, 2'd0, 2,     2 * W,     1'b0, 16'h1F00, 1'b0);
        frame("dec2",    2'($urandom_range(0, 3)), 2'd1, 2 * H, 4 * W, 1'b1, 16'h0, 1'b0);
        frame("dec2end", 2'd0, 2'd0, 2 * H, 4 * W,     1'b1, 16'h0, 1'b0);
        frame("ovf",     2'd2, 2'd2, 4 * H, 8 * W,     1'b1, 16'h0, 1'b0);
        frame("dec4",    2'd0, 2'd1, 5,     2 * W,     1'b1, 16'h0, 1'b1);
        frame("midmode", 2'd1, 2'd0, 4,     2 * W + 1, 1'b1, 16'h0, 1'b0);
        frame("odd",     2'd0, 2'd0, 0,     0,         1'b1, 16'h0, 1'b0);

        // Frame whose first line rises together with VSYNC
        bus.MODE = 2'd2;
        send_line(2 * W, 1'b1, 16'h0, 1'b1);
        check_status("vs_href");
        send_line(2 * W, 1'b1, 16'h0, 1'b0);

        // Reset between lines of a running frame
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_outputs", {bus.W_EN, bus.WR_DATA, bus.WR_ADDR, bus.FRAME_DONE,
                                   bus.FRAME_CNT, bus.OVERFLOW, bus.BUSY}, 0);
        check("midreset_pending", exp_q.size(), 0);
        busy_exp = 0;
        cnt_exp = 0;
        ovf_exp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send_line(2 * W, 1'b1, 16'h0, 1'b0);
        check("postreset_busy", bus.BUSY, 0);
        frame("rearm", 2'd0, 2'd0, 1, 2 * W, 1'b1, 16'h0, 1'b0);

        // Counter wrap with empty frames
        for (int f = 0; f < 256; f++) begin
            vsync_edge();
            if (f == 254) check("frame_cnt_255", bus.FRAME_CNT, cnt_exp);
        end
        check_status("wrap");
        check("frame_cnt_wrapped", bus.FRAME_CNT, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
